// File: rtl/fifo_pkg.sv
// Constants and types shared by the Sync_FIFO read-side logic and its benches.
// The skid depth of 2 covers the FIFO's one-cycle registered read latency.
package fifo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W      = $clog2(SKID_DEPTH);

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W:0]   lvl_t;
endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry register skid buffer: writes at the tail, presents the head.
// An entry is never overwritten while it is the head, so head stays stable until popped.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output occ_t              occ,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] mem_d [SKID_DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  occ_t occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    occ_d = occ_q + occ_t'(wr) - occ_t'(rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];
endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for Sync_FIFO: issues rd strobes, captures data_out a cycle
// later into a skid buffer and delivers it on a valid/ready stream.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);
  occ_t             occ;
  logic             pop;
  lvl_t             level;
  logic             rd_issue;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  // Slots committed after this edge; a read is only issued if its data is sure to fit.
  // Gating with rst keeps fifo_rd low while reset is held.
  always_comb begin
    pop        = (occ != '0) && out_ready;
    level      = lvl_t'(occ) + lvl_t'(inflight_q) - lvl_t'(pop);
    rd_issue   = rst && enable && !fifo_empty && (level < lvl_t'(SKID_DEPTH));
    inflight_d = rd_issue;
    word_cnt_d = word_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr      (inflight_q),
    .wr_data (fifo_dout),
    .rd      (pop),
    .occ     (occ),
    .head    (out_data)
  );

  assign fifo_rd   = rd_issue;
  assign out_valid = (occ != '0);
  assign busy      = (occ != '0) || inflight_q;
  assign word_cnt  = word_cnt_q;
endmodule

// File: doc/sync_fifo_reader.md
Name: sync_fifo_reader

Overview:
- Read-side controller for the team's synchronous FIFO (Sync_FIFO). It drives the FIFO's rd strobe from its empty flag and captures data_out one cycle after each read.
- It presents the words downstream on a valid/ready stream.
- A 2-entry skid buffer absorbs the FIFO's registered read latency, so the block sustains one word per cycle under back-pressure with no loss or duplication.
- Sits between Sync_FIFO and any consumer (UART TX, packet builder, ...).

Parameters:
- DATA_W, 8, width of FIFO data and stream data.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  rising-edge clock, shared with Sync_FIFO.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  1 = fetch from FIFO; 0 = stop issuing reads, keep delivering buffered/in-flight words.
- fifo_empty  input  1  Sync_FIFO empty flag.
- fifo_dout  input  DATA_W  Sync_FIFO data_out, valid in the cycle after fifo_rd was sampled.
- fifo_rd  output  1  read strobe to Sync_FIFO rd, combinational.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge.
- out_data  output  DATA_W  head of skid buffer.
- busy  output  1  occupancy != 0 or a read is in flight.
- word_cnt  output  CNT_W  count of stream handshakes since reset; wraps modulo 2^CNT_W.

Behaviour:
Reset (rst=0, async):
- occ=0, inflight=0, buffer pointers=0.
- fifo_rd=0, out_valid=0, out_data=0, busy=0, word_cnt=0.
- Reset mid-operation discards buffered and in-flight words. The FIFO is reset in the same domain.

Definitions:
- occ: 0..2, entries in the skid buffer.
- inflight: 1 if fifo_rd was high at the previous edge.
- pop = out_valid && out_ready.

Read issue (combinational):
- fifo_rd = enable && !fifo_empty && (occ + inflight - pop < 2).
- Never asserted while fifo_empty=1.
- An in-flight read always has a guaranteed slot.

Capture:
- At each edge where inflight=1, fifo_dout is written at the tail.
- A write and a pop in the same edge are allowed; occ is unchanged in that case.

Stream output:
- out_valid = (occ != 0).
- out_data = head entry; 0 when occ=0 is not required (don't-care).
- out_data and out_valid must remain stable while out_valid=1 and out_ready=0.

Throughput and latency:
- Steady state with out_ready held at 1: one word per cycle.
- First word appears at out_valid 2 edges after the first fifo_rd (edge 1: FIFO read; edge 2: capture).

Ordering:
- Words delivered in FIFO order, exactly once.

enable deasserted:
- fifo_rd=0 from that same cycle.
- The pending in-flight word is still captured.
- busy falls once occ=0 and inflight=0.

Counters:
- word_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.

Protocol:
- No combinational path from out_ready to out_valid.
- out_ready only affects fifo_rd (via pop).

Decomposition:
- Package fifo_pkg: DATA_W default, SKID_DEPTH=2 constant, CNT_W default. Shared with Sync_FIFO and its bench.
- One sub-module: rd_skid_buf, a 2-entry register buffer with wr/rd/occ. sync_fifo_reader holds the issue logic, inflight flag and word_cnt.

Test Plan:
1. Reset then push 1,2,3 into FIFO, enable=1, out_ready=1 -> fifo_rd high 3 consecutive cycles; out_data 1,2,3 on consecutive cycles starting 2 edges after first fifo_rd; word_cnt=3; busy=0 afterwards.
2. Fill FIFO with 10..130 (13 words), out_ready=0 -> exactly 2 fifo_rd pulses, occ=2, out_data=10 held stable; then out_ready=1 -> 10..130 in order, no gaps, no duplicates.
3. Toggle out_ready 1,0,1,0 while FIFO holds 20 words -> every accepted word matches the FIFO order; fifo_rd never asserted while occ+inflight=2 without a pop.
4. FIFO empty, enable=1 -> fifo_rd stays 0; push 140 -> fifo_rd one cycle, out_data=140; simultaneous push 5 and pop the same cycle -> 5 delivered next.
5. enable=0 one cycle after a fifo_rd while FIFO holds 4 words -> in-flight word delivered, no further fifo_rd; FIFO fifo_cnt stays at 3.
6. Assert rst=0 mid-stream with occ=2 -> all outputs 0 immediately (asynchronously, without a clock edge); after release, out_valid=0 until new data is pushed.
